secuenciador_math: RTL and testbench

Sequenced arithmetic unit for unsigned WIDTH-bit operands. It accepts one operation per request through a start/ready handshake. Add, subtract and multiply complete in a single cycle. Division uses an iterative restoring algorithm, which gives the codebase a synthesizable divider. The block sits between a requester (pushbutton/switch front end or a higher-level controller) and the display/result logic, and owns all sequencing of the arithmetic datapath.

---
 rtl/secuenciador_math_pkg.sv | 15 +
 rtl/secuenciador_math_paso_division.sv | 33 +++
 rtl/secuenciador_math.sv | 153 +++++++++++++++
 tb/tb_secuenciador_math.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/secuenciador_math_pkg.sv
// Shared op codes and FSM state encodings for the sequenced arithmetic unit.
package secuenciador_math_pkg;

  localparam logic [1:0] OP_SUMA  = 2'b00;
  localparam logic [1:0] OP_RESTA = 2'b01;
  localparam logic [1:0] OP_MULT  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    ST_REPOSO = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_FIN    = 2'd2
  } estado_t;

endpackage

// File: rtl/secuenciador_math_paso_division.sv
// One combinational restoring-division step: shift {R,Q} left, then
// subtract the divisor from R when it fits and set the new quotient bit.
module paso_division #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   r_sig,
  output logic [WIDTH-1:0] q_sig
);

  logic [WIDTH+1:0] r_desp;
  logic [WIDTH+1:0] div_ext;
  logic [WIDTH+1:0] r_resta;
  logic [WIDTH-1:0] q_desp;

  // Shift, trial-subtract and restore when the divisor does not fit.
  always_comb begin
    r_desp  = {r, q[WIDTH-1]};
    div_ext = {2'b00, divisor};
    r_resta = r_desp - div_ext;
    q_desp  = {q[WIDTH-2:0], 1'b0};
    if (r_desp >= div_ext) begin
      r_sig = r_resta[WIDTH:0];
      q_sig = q_desp | {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_sig = r_desp[WIDTH:0];
      q_sig = q_desp;
    end
  end

endmodule

// File: rtl/secuenciador_math.sv
// Sequenced arithmetic unit: single-cycle add/sub/mul and an iterative
// restoring divider, behind a start/ready handshake.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// REPOSO    | idle, listo=1, waiting for inicio
// DIVIDE    | one restoring step per cycle, WIDTH cycles total
// FIN       | results registered, valido=1 for this single cycle
module secuenciador_math
  import secuenciador_math_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inicio,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  output logic                 listo,
  output logic                 valido,
  output logic [2*WIDTH-1:0]   resultado,
  output logic [WIDTH-1:0]     residuo,
  output logic                 div_cero
);

  localparam int CW = $clog2(WIDTH + 1);

  estado_t estado, estado_sig;

  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sig;
  logic [WIDTH-1:0] q_sig;

  logic cargar_div, cargar_simple, paso, fin_div;

  logic [WIDTH:0]       suma_w;
  logic [WIDTH-1:0]     resta_w;
  logic [2*WIDTH-1:0]   mult_w;
  logic [2*WIDTH-1:0]   res_simple;
  logic [WIDTH-1:0]     resid_simple;
  logic                 cero_simple;

  paso_division #(.WIDTH(WIDTH)) u_paso (
    .r       (r_q),
    .q       (q_q),
    .divisor (div_q),
    .r_sig   (r_sig),
    .q_sig   (q_sig)
  );

  assign listo  = (estado == ST_REPOSO);
  assign valido = (estado == ST_FIN);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) estado <= ST_REPOSO;
    else     estado <= estado_sig;
  end

  // Next-state decode and datapath load strobes.
  always_comb begin
    estado_sig    = estado;
    cargar_div    = 1'b0;
    cargar_simple = 1'b0;
    paso          = 1'b0;
    fin_div       = 1'b0;
    case (estado)
      ST_REPOSO: begin
        if (inicio) begin
          if (op == OP_DIV && num2 != '0) begin
            cargar_div = 1'b1;
            estado_sig = ST_DIVIDE;
          end else begin
            cargar_simple = 1'b1;
            estado_sig    = ST_FIN;
          end
        end
      end
      ST_DIVIDE: begin
        paso = 1'b1;
        if (cnt == CW'(1)) begin
          fin_div    = 1'b1;
          estado_sig = ST_FIN;
        end
      end
      ST_FIN:  estado_sig = ST_REPOSO;
      default: estado_sig = ST_REPOSO;
    endcase
  end

  // Single-cycle results, including the divide-by-zero result.
  always_comb begin
    suma_w       = {1'b0, num1} + {1'b0, num2};
    resta_w      = num1 - num2;
    mult_w       = {{WIDTH{1'b0}}, num1} * {{WIDTH{1'b0}}, num2};
    res_simple   = '0;
    resid_simple = '0;
    cero_simple  = 1'b0;
    case (op)
      OP_SUMA:  res_simple = {{(WIDTH-1){1'b0}}, suma_w};
      OP_RESTA: res_simple = {{WIDTH{1'b0}}, resta_w};
      OP_MULT:  res_simple = mult_w;
      default: begin
        res_simple   = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
        resid_simple = num1;
        cero_simple  = 1'b1;
      end
    endcase
  end

  // Iteration registers: operands are captured at accept so later input
  // changes cannot disturb a division in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      q_q   <= '0;
      div_q <= '0;
      cnt   <= '0;
    end else if (cargar_div) begin
      r_q   <= '0;
      q_q   <= num1;
      div_q <= num2;
      cnt   <= CW'(WIDTH);
    end else if (paso) begin
      r_q   <= r_sig;
      q_q   <= q_sig;
      cnt   <= cnt - CW'(1);
    end
  end

  // Result registers, updated only on the transition into FIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      resultado <= '0;
      residuo   <= '0;
      div_cero  <= 1'b0;
    end else if (cargar_simple) begin
      resultado <= res_simple;
      residuo   <= resid_simple;
      div_cero  <= cero_simple;
    end else if (fin_div) begin
      resultado <= {{WIDTH{1'b0}}, q_sig};
      residuo   <= r_sig[WIDTH-1:0];
      div_cero  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_secuenciador_math.sv
// Directed testbench for secuenciador_math with WIDTH=4.
module tb_secuenciador_math;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inicio = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] num1 = 4'd0;
  logic [3:0] num2 = 4'd0;
  logic       listo, valido, div_cero;
  logic [7:0] resultado;
  logic [3:0] residuo;

  int n_cmp = 0;
  int n_err = 0;

  secuenciador_math #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .op        (op),
    .num1      (num1),
    .num2      (num2),
    .listo     (listo),
    .valido    (valido),
    .resultado (resultado),
    .residuo   (residuo),
    .div_cero  (div_cero)
  );

  always #5 clk = ~clk;

  // Present a request at a falling edge and let the next rising edge take it.
  task automatic lanzar(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    inicio = 1'b1; op = o; num1 = a; num2 = b;
    @(posedge clk);
    #1 inicio = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (listo !== 1'b1) begin n_err++; $display("FAIL reset_listo got %b want 1", listo); end
    n_cmp++; if (valido !== 1'b0) begin n_err++; $display("FAIL reset_valido got %b want 0", valido); end
    n_cmp++; if (resultado !== 8'h00) begin n_err++; $display("FAIL reset_resultado got %h want 00", resultado); end
    n_cmp++; if (residuo !== 4'h0) begin n_err++; $display("FAIL reset_residuo got %h want 0", residuo); end
    n_cmp++; if (div_cero !== 1'b0) begin n_err++; $display("FAIL reset_div_cero got %b want 0", div_cero); end
  endtask

  task automatic test_suma;
    lanzar(2'b00, 4'd9, 4'd8);
    @(negedge clk);
    n_cmp++; if (valido !== 1'b1) begin n_err++; $display("FAIL suma_valido got %b want 1", valido); end
    n_cmp++; if (listo !== 1'b0) begin n_err++; $display("FAIL suma_listo_fin got %b want 0", listo); end
    n_cmp++; if (resultado !== 8'h11) begin n_err++; $display("FAIL suma_resultado got %h want 11", resultado); end
    n_cmp++; if (residuo !== 4'h0) begin n_err++; $display("FAIL suma_residuo got %h want 0", residuo); end
    n_cmp++; if (div_cero !== 1'b0) begin n_err++; $display("FAIL suma_div_cero got %b want 0", div_cero); end
    @(negedge clk);
    n_cmp++; if (valido !== 1'b0) begin n_err++; $display("FAIL suma_valido_pulse got %b want 0", valido); end
    n_cmp++; if (listo !== 1'b1) begin n_err++; $display("FAIL suma_listo_after got %b want 1", listo); end
    n_cmp++; if (resultado !== 8'h11) begin n_err++; $display("FAIL suma_hold got %h want 11", resultado); end
  endtask

  task automatic test_resta_mult;
    lanzar(2'b01, 4'd3, 4'd5);
    @(negedge clk);
    n_cmp++; if (valido !== 1'b1) begin n_err++; $display("FAIL resta_valido got %b want 1", valido); end
    n_cmp++; if (resultado !== 8'h0E) begin n_err++; $display("FAIL resta_resultado got %h want 0e", resultado); end
    @(negedge clk);
    n_cmp++; if (listo !== 1'b1) begin n_err++; $display("FAIL mult_first_listo got %b want 1", listo); end
    inicio = 1'b1; op = 2'b10; num1 = 4'd15; num2 = 4'd15;
    @(posedge clk);
    #1 inicio = 1'b0;
    @(negedge clk);
    n_cmp++; if (valido !== 1'b1) begin n_err++; $display("FAIL mult_valido got %b want 1", valido); end
    n_cmp++; if (resultado !== 8'hE1) begin n_err++; $display("FAIL mult_resultado got %h want e1", resultado); end
    n_cmp++; if (residuo !== 4'h0) begin n_err++; $display("FAIL mult_residuo got %h want 0", residuo); end
  endtask

  task automatic test_division;
    lanzar(2'b11, 4'd13, 4'd3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++; if (listo !== 1'b0) begin n_err++; $display("FAIL div_listo cycle %0d got %b want 0", k, listo); end
      n_cmp++; if (valido !== (k == 5)) begin n_err++; $display("FAIL div_valido cycle %0d got %b want %b", k, valido, (k == 5)); end
    end
    n_cmp++; if (resultado !== 8'h04) begin n_err++; $display("FAIL div_resultado got %h want 04", resultado); end
    n_cmp++; if (residuo !== 4'h1) begin n_err++; $display("FAIL div_residuo got %h want 1", residuo); end
    n_cmp++; if (div_cero !== 1'b0) begin n_err++; $display("FAIL div_div_cero got %b want 0", div_cero); end
    @(negedge clk);
    n_cmp++; if (listo !== 1'b1) begin n_err++; $display("FAIL div_listo_after got %b want 1", listo); end
  endtask

  task automatic test_div_cero;
    lanzar(2'b11, 4'd7, 4'd0);
    @(negedge clk);
    n_cmp++; if (valido !== 1'b1) begin n_err++; $display("FAIL dz_valido got %b want 1", valido); end
    n_cmp++; if (resultado !== 8'h0F) begin n_err++; $display("FAIL dz_resultado got %h want 0f", resultado); end
    n_cmp++; if (residuo !== 4'h7) begin n_err++; $display("FAIL dz_residuo got %h want 7", residuo); end
    n_cmp++; if (div_cero !== 1'b1) begin n_err++; $display("FAIL dz_div_cero got %b want 1", div_cero); end
    lanzar(2'b00, 4'd1, 4'd1);
    @(negedge clk);
    n_cmp++; if (resultado !== 8'h02) begin n_err++; $display("FAIL dz_suma_resultado got %h want 02", resultado); end
    n_cmp++; if (div_cero !== 1'b0) begin n_err++; $display("FAIL dz_clear got %b want 0", div_cero); end
    n_cmp++; if (residuo !== 4'h0) begin n_err++; $display("FAIL dz_suma_residuo got %h want 0", residuo); end
  endtask

  task automatic test_ignora_inicio;
    int pulsos;
    pulsos = 0;
    @(negedge clk);
    inicio = 1'b1; op = 2'b11; num1 = 4'd15; num2 = 4'd2;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (valido === 1'b1) begin
        pulsos++;
        n_cmp++; if (k != 5) begin n_err++; $display("FAIL ign_valido_cycle got %0d want 5", k); end
        n_cmp++; if (resultado !== 8'h07) begin n_err++; $display("FAIL ign_resultado got %h want 07", resultado); end
        n_cmp++; if (residuo !== 4'h1) begin n_err++; $display("FAIL ign_residuo got %h want 1", residuo); end
      end
      if (k < 5) begin
        op = 2'(k); num1 = 4'(k + 1); num2 = 4'(k * 3);
      end else begin
        inicio = 1'b0;
      end
    end
    n_cmp++; if (pulsos != 1) begin n_err++; $display("FAIL ign_pulsos got %0d want 1", pulsos); end
  endtask

  task automatic test_reset_mid;
    int espera;
    logic visto;
    lanzar(2'b11, 4'd12, 4'd5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (listo !== 1'b1) begin n_err++; $display("FAIL rm_listo got %b want 1", listo); end
    n_cmp++; if (resultado !== 8'h00) begin n_err++; $display("FAIL rm_resultado got %h want 00", resultado); end
    n_cmp++; if (residuo !== 4'h0) begin n_err++; $display("FAIL rm_residuo got %h want 0", residuo); end
    n_cmp++; if (div_cero !== 1'b0) begin n_err++; $display("FAIL rm_div_cero got %b want 0", div_cero); end
    visto = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (valido === 1'b1) visto = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (visto !== 1'b0) begin n_err++; $display("FAIL rm_no_valido got %b want 0", visto); end
    lanzar(2'b11, 4'd12, 4'd5);
    espera = 0;
    visto = 1'b0;
    while (!visto && espera < 20) begin
      @(negedge clk);
      espera++;
      if (valido === 1'b1) visto = 1'b1;
    end
    n_cmp++; if (visto !== 1'b1) begin n_err++; $display("FAIL rm_timeout got %b want 1", visto); end
    n_cmp++; if (espera != 5) begin n_err++; $display("FAIL rm_latencia got %0d want 5", espera); end
    n_cmp++; if (resultado !== 8'h02) begin n_err++; $display("FAIL rm_resultado2 got %h want 02", resultado); end
    n_cmp++; if (residuo !== 4'h2) begin n_err++; $display("FAIL rm_residuo2 got %h want 2", residuo); end
  endtask

  initial begin
    test_reset();
    test_suma();
    test_resta_mult();
    test_division();
    test_div_cero();
    test_ignora_inicio();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
